// File: rtl/spi_master_if.sv
// Bundle of the spi_master host handshake and SPI pins.
// "master" is the view of the spi_master block itself; "slave" is the view of
// whatever sits on the other side (host logic supplying words plus the SPI peer).
interface spi_master_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VLD;
  logic             DIN_RDY;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VLD;
  logic             BUSY;
  logic             SCLK;
  logic             CS_N;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  DIN, DIN_VLD, MISO,
    output DIN_RDY, DOUT, DOUT_VLD, BUSY, SCLK, CS_N, MOSI
  );

  modport slave (
    output DIN, DIN_VLD, MISO,
    input  DIN_RDY, DOUT, DOUT_VLD, BUSY, SCLK, CS_N, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Single-word SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Frames one WIDTH-bit word per CS_N assertion and returns the word captured on MISO.
// Every pin and status output comes straight from a flop; SCLK is a registered toggle.
module spi_master #(
  parameter int WIDTH    = 64,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  spi_master_if.master bus
);

  localparam int CNT_W = 16;
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;       // cycles left in the current phase
  logic [BIT_W-1:0]   bit_reg, bit_next;       // bits left after the current one
  logic [WIDTH-1:0]   tx_reg, tx_next;         // MSB is the bit on MOSI
  logic [WIDTH-1:0]   rx_reg, rx_next;
  logic [WIDTH-1:0]   dout_reg, dout_next;
  logic               dout_vld_reg, dout_vld_next;
  logic               sclk_reg, sclk_next;
  logic               cs_n_reg, cs_n_next;
  logic               din_rdy_reg, din_rdy_next;
  logic               busy_reg, busy_next;

  // State and datapath registers; reset abandons any frame immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
      sclk_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      din_rdy_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      dout_reg     <= dout_next;
      dout_vld_reg <= dout_vld_next;
      sclk_reg     <= sclk_next;
      cs_n_reg     <= cs_n_next;
      din_rdy_reg  <= din_rdy_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state and datapath decode for the frame sequencer
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    dout_next     = dout_reg;
    dout_vld_next = 1'b0;
    sclk_next     = sclk_reg;
    cs_n_next     = cs_n_reg;

    case (state_reg)
      IDLE: begin
        // din_rdy_reg is low on the first cycle out of reset, so nothing is taken then
        if (din_rdy_reg && bus.DIN_VLD) begin
          tx_next    = bus.DIN;
          cs_n_next  = 1'b0;
          cnt_next   = CNT_W'(CS_SETUP - 1);
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (cnt_reg == '0) begin
          cnt_next   = CNT_W'(CLK_DIV - 1);
          bit_next   = BIT_W'(WIDTH - 1);
          state_next = XFER;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      XFER: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          cnt_next = CNT_W'(CLK_DIV - 1);
          if (!sclk_reg) begin
            // Rising edge: capture MISO, which the peer changed on the previous fall
            sclk_next = 1'b1;
            rx_next   = {rx_reg[WIDTH-2:0], bus.MISO};
          end else begin
            // Falling edge: present the next bit; the last shift leaves MOSI at 0
            sclk_next = 1'b0;
            tx_next   = {tx_reg[WIDTH-2:0], 1'b0};
            if (bit_reg == '0) begin
              cnt_next   = CNT_W'(CS_HOLD - 1);
              state_next = HOLD;
            end else begin
              bit_next = bit_reg - 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (cnt_reg == '0) begin
          cs_n_next     = 1'b1;
          dout_next     = rx_reg;
          dout_vld_next = 1'b1;
          cnt_next      = CNT_W'(CS_GAP - 1);
          state_next    = GAP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      GAP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered status follows the state being entered
    din_rdy_next = (state_next == IDLE);
    busy_next    = (state_next != IDLE);
  end

  assign bus.DIN_RDY  = din_rdy_reg;
  assign bus.DOUT     = dout_reg;
  assign bus.DOUT_VLD = dout_vld_reg;
  assign bus.BUSY     = busy_reg;
  assign bus.SCLK     = sclk_reg;
  assign bus.CS_N     = cs_n_reg;
  assign bus.MOSI     = tx_reg[WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: 64-bit default instance plus an 8-bit, CLK_DIV=2 instance.
module tb_spi_master;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  spi_master_if #(.WIDTH(64)) bus_a ();
  spi_master_if #(.WIDTH(8))  bus_b ();

  spi_master u_dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
  spi_master #(.WIDTH(8), .CLK_DIV(2)) u_dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Edge counter used to time-stamp observed events
  always @(posedge CLK) cyc <= cyc + 1;

  // MISO source for instance A: loopback or a peer that shifts a pattern on SCLK fall
  logic        loop_a   = 1'b1;
  logic [63:0] miso_pat = 64'h0;
  logic        miso_model;
  int          fall_idx = 0;
  always_comb miso_model = (fall_idx >= 0 && fall_idx < 64) ? miso_pat[63 - fall_idx] : 1'b0;
  assign bus_a.MISO = loop_a ? bus_a.MOSI : miso_model;
  assign bus_b.MISO = bus_b.MOSI;

  // Event monitor for instance A, sampled mid-cycle
  logic prev_sclk_a = 1'b0, prev_cs_a = 1'b1, prev_rdy_a = 1'b0, busy_seen_a = 1'b0;
  int rise_cnt_a = 0, rise_total_a = 0, first_rise_a = 0, cs_fall_a = 0, cs_fall_prev_a = 0;
  int cs_fall_cnt_a = 0, cs_rise_a = 0, vld_cnt_a = 0, vld_cyc_a = 0, rdy_rise_a = 0, mosi_low_hi_a = 0;
  always @(negedge CLK) begin
    prev_sclk_a <= bus_a.SCLK;
    prev_cs_a   <= bus_a.CS_N;
    prev_rdy_a  <= bus_a.DIN_RDY;
    if (bus_a.SCLK && !prev_sclk_a) begin
      rise_cnt_a   <= rise_cnt_a + 1;
      rise_total_a <= rise_total_a + 1;
      if (rise_cnt_a == 0) first_rise_a <= cyc;
    end
    if (!bus_a.SCLK && prev_sclk_a) fall_idx <= fall_idx + 1;
    if (!bus_a.CS_N && prev_cs_a) begin
      rise_cnt_a     <= 0;
      fall_idx       <= 0;
      cs_fall_prev_a <= cs_fall_a;
      cs_fall_a      <= cyc;
      cs_fall_cnt_a  <= cs_fall_cnt_a + 1;
    end
    if (bus_a.CS_N && !prev_cs_a) cs_rise_a <= cyc;
    if (bus_a.DOUT_VLD) begin
      vld_cnt_a <= vld_cnt_a + 1;
      vld_cyc_a <= cyc;
    end
    if (bus_a.DIN_RDY && !prev_rdy_a) rdy_rise_a <= cyc;
    if (bus_a.SCLK && !bus_a.MOSI) mosi_low_hi_a <= mosi_low_hi_a + 1;
    if (bus_a.BUSY) busy_seen_a <= 1'b1;
  end

  // Event monitor for instance B: rise count and SCLK period
  logic prev_sclk_b = 1'b0, prev_cs_b = 1'b1;
  int rise_cnt_b = 0, last_rise_b = -1, bad_per_b = 0, vld_cnt_b = 0, first_rise_b = 0, cs_fall_b = 0;
  always @(negedge CLK) begin
    prev_sclk_b <= bus_b.SCLK;
    prev_cs_b   <= bus_b.CS_N;
    if (bus_b.SCLK && !prev_sclk_b) begin
      rise_cnt_b  <= rise_cnt_b + 1;
      last_rise_b <= cyc;
      if (rise_cnt_b == 0) first_rise_b <= cyc;
      if (last_rise_b >= 0 && cyc - last_rise_b != 4) bad_per_b <= bad_per_b + 1;
    end
    if (!bus_b.CS_N && prev_cs_b) begin
      rise_cnt_b  <= 0;
      last_rise_b <= -1;
      cs_fall_b   <= cyc;
    end
    if (bus_b.DOUT_VLD) vld_cnt_b <= vld_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_a(input logic [63:0] word);
    bus_a.DIN     = word;
    bus_a.DIN_VLD = 1'b1;
    step(1);
    bus_a.DIN_VLD = 1'b0;
  endtask

  // Bounded wait for instance A to return to IDLE, then let the monitor catch up
  task automatic wait_rdy_a(input string tag);
    int i;
    i = 0;
    while (!bus_a.DIN_RDY && i < 700) begin
      step(1);
      i++;
    end
    check({tag, " rdy_timeout"}, 64'(bus_a.DIN_RDY), 64'd1);
    step(1);
  endtask

  int v0, c0, m0, vb, bp;

  initial begin
    bus_a.DIN = '0; bus_a.DIN_VLD = 1'b0;
    bus_b.DIN = '0; bus_b.DIN_VLD = 1'b0;

    // Reset values
    step(3);
    check("rst din_rdy",  64'(bus_a.DIN_RDY),  64'd0);
    check("rst dout",     bus_a.DOUT,          64'd0);
    check("rst dout_vld", 64'(bus_a.DOUT_VLD), 64'd0);
    check("rst busy",     64'(bus_a.BUSY),     64'd0);
    check("rst sclk",     64'(bus_a.SCLK),     64'd0);
    check("rst cs_n",     64'(bus_a.CS_N),     64'd1);
    check("rst mosi",     64'(bus_a.MOSI),     64'd0);
    RST_N = 1'b1;
    step(1);
    check("rdy after rst",   64'(bus_a.DIN_RDY), 64'd1);
    check("rdy after rst b", 64'(bus_b.DIN_RDY), 64'd1);

    // Idle with DIN_VLD low
    step(1000);
    check("idle rises",    64'(rise_total_a),  64'd0);
    check("idle cs falls", 64'(cs_fall_cnt_a), 64'd0);
    check("idle vld",      64'(vld_cnt_a),     64'd0);
    check("idle busy",     64'(busy_seen_a),   64'd0);
    check("idle cs_n",     64'(bus_a.CS_N),    64'd1);
    $display("[TB] idle 1000 cycles done");

    // Loopback frame with default timing
    v0 = vld_cnt_a;
    send_a(64'h0100_0000_0000_0022);
    wait_rdy_a("t1");
    check("t1 rises",      64'(rise_cnt_a),               64'd64);
    check("t1 first rise", 64'(first_rise_a - cs_fall_a), 64'd8);
    check("t1 cs_n high",  64'(cs_rise_a - cs_fall_a),    64'd520);
    check("t1 vld count",  64'(vld_cnt_a - v0),           64'd1);
    check("t1 vld time",   64'(vld_cyc_a - cs_fall_a),    64'd520);
    check("t1 rdy time",   64'(rdy_rise_a - cs_fall_a),   64'd528);
    check("t1 dout",       bus_a.DOUT,                    64'h0100_0000_0000_0022);
    $display("[TB] frame t1 din=%h dout=%h", 64'h0100_0000_0000_0022, bus_a.DOUT);

    // Peer-driven MISO pattern, all-ones on MOSI
    loop_a   = 1'b0;
    miso_pat = 64'hA5A5_5A5A_0F0F_F0F0;
    m0 = mosi_low_hi_a;
    send_a(64'hFFFF_FFFF_FFFF_FFFF);
    wait_rdy_a("t2");
    check("t2 dout",          bus_a.DOUT,                64'hA5A5_5A5A_0F0F_F0F0);
    check("t2 mosi low in hi", 64'(mosi_low_hi_a - m0),  64'd0);
    check("t2 rises",         64'(rise_cnt_a),           64'd64);
    $display("[TB] frame t2 din=%h dout=%h", 64'hFFFF_FFFF_FFFF_FFFF, bus_a.DOUT);
    loop_a = 1'b1;

    // DIN_VLD held: back-to-back frames, DIN changed during the first
    c0 = cs_fall_cnt_a;
    v0 = vld_cnt_a;
    bus_a.DIN     = 64'h1;
    bus_a.DIN_VLD = 1'b1;
    step(1);
    bus_a.DIN = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 700 && vld_cnt_a == v0; i++) step(1);
    check("t3 first dout", bus_a.DOUT, 64'h1);
    $display("[TB] frame t3a din=%h dout=%h", 64'h1, bus_a.DOUT);
    for (int i = 0; i < 700 && cs_fall_cnt_a < c0 + 2; i++) step(1);
    bus_a.DIN_VLD = 1'b0;
    check("t3 frame spacing", 64'(cs_fall_a - cs_fall_prev_a), 64'd529);
    wait_rdy_a("t3");
    check("t3 second dout", bus_a.DOUT,                64'h8000_0000_0000_0000);
    check("t3 vld count",   64'(vld_cnt_a - v0),       64'd2);
    check("t3 frame count", 64'(cs_fall_cnt_a - c0),   64'd2);
    $display("[TB] frame t3b din=%h dout=%h", 64'h8000_0000_0000_0000, bus_a.DOUT);

    // Reset in the middle of a frame
    send_a(64'h1234_5678_9ABC_DEF0);
    v0 = vld_cnt_a;
    step(200);
    check("t4 sclk before rst", 64'(bus_a.SCLK), 64'd1);
    RST_N = 1'b0;
    #1;
    check("t4 cs_n async",  64'(bus_a.CS_N),    64'd1);
    check("t4 sclk async",  64'(bus_a.SCLK),    64'd0);
    check("t4 dout async",  bus_a.DOUT,         64'd0);
    check("t4 busy async",  64'(bus_a.BUSY),    64'd0);
    check("t4 rdy async",   64'(bus_a.DIN_RDY), 64'd0);
    step(3);
    RST_N = 1'b1;
    step(20);
    check("t4 no vld",      64'(vld_cnt_a - v0), 64'd0);
    check("t4 dout zero",   bus_a.DOUT,          64'd0);
    send_a(64'hDEAD_BEEF_0123_4567);
    wait_rdy_a("t4");
    check("t4 new dout",    bus_a.DOUT,          64'hDEAD_BEEF_0123_4567);
    check("t4 new rises",   64'(rise_cnt_a),     64'd64);
    $display("[TB] frame t4 din=%h dout=%h", 64'hDEAD_BEEF_0123_4567, bus_a.DOUT);

    // Narrow fast instance: WIDTH=8, CLK_DIV=2
    vb = vld_cnt_b;
    bp = bad_per_b;
    bus_b.DIN     = 8'hC3;
    bus_b.DIN_VLD = 1'b1;
    step(1);
    bus_b.DIN_VLD = 1'b0;
    for (int i = 0; i < 100 && !bus_b.DIN_RDY; i++) step(1);
    step(1);
    check("t5 rdy",        64'(bus_b.DIN_RDY),           64'd1);
    check("t5 rises",      64'(rise_cnt_b),              64'd8);
    check("t5 period",     64'(bad_per_b - bp),          64'd0);
    check("t5 first rise", 64'(first_rise_b - cs_fall_b), 64'd6);
    check("t5 vld count",  64'(vld_cnt_b - vb),          64'd1);
    check("t5 dout",       64'(bus_b.DOUT),              64'hC3);
    $display("[TB] frame t5 din=c3 dout=%h", bus_b.DOUT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-word SPI master that drives the on-board 64-bit spi_slave command channel, and any peripheral using the same framing.
- Accepts a 64-bit word on a valid/ready handshake and frames it with CS_N.
- Shifts it out MSB-first on MOSI in SPI mode 0 (CPOL=0, CPHA=0), capturing 64 bits from MISO in the same frame.
- Returns the captured word with a one-cycle DOUT_VLD strobe. Used by the bench and by the control FPGA path as the peer of spi_slave.

Parameters:
- WIDTH, 64, bits per frame (≥2).
- CLK_DIV, 4, CLK cycles per SCLK half-period (≥2).
- CS_SETUP, 4, CLK cycles from CS_N fall to the start of the first SCLK low half-period (≥1).
- CS_HOLD, 4, CLK cycles from the last SCLK fall to CS_N rise (≥1).
- CS_GAP, 8, CLK cycles CS_N stays high before the next word is accepted (≥1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; one clock, asynchronous assert, active-low.
- DIN  in  WIDTH  word to transmit.
- DIN_VLD  in  1  DIN valid.
- DIN_RDY  out  1  master can accept DIN.
- DOUT  out  WIDTH  last word received on MISO.
- DOUT_VLD  out  1  one-cycle strobe, DOUT updated.
- BUSY  out  1  frame in progress (not IDLE).
- SCLK  out  1  SPI clock, idle low.
- CS_N  out  1  chip select, active low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

Behaviour:
- Reset (RST_N=0, asynchronous): DIN_RDY=0, DOUT=0, DOUT_VLD=0, BUSY=0, SCLK=0, CS_N=1, MOSI=0, state=IDLE. DIN_RDY rises on the first CLK edge after release.
- All outputs are registered. SCLK is generated from CLK, never gated or derived combinationally.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE:
  - DIN_RDY=1, CS_N=1, SCLK=0.
  - On an edge T0 with DIN_VLD=1: latch DIN into the TX shift register, CS_N<=0, MOSI<=DIN[WIDTH-1], DIN_RDY<=0, BUSY<=1, go SETUP.
- SETUP: hold for CS_SETUP cycles, SCLK=0, then go XFER.
- XFER:
  - Per bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - First rise at T0+CS_SETUP+CLK_DIV.
  - On the edge that drives SCLK high, sample MISO into the RX shift register LSB (shift left).
  - On the edge that drives SCLK low, shift TX and drive the next bit on MOSI. MOSI is stable for the whole high half-period.
  - After WIDTH rising edges, the final fall (at T0+CS_SETUP+2·CLK_DIV·WIDTH) sets MOSI<=0 and enters HOLD.
  - Bit counter runs from WIDTH-1 down to 0. No extra SCLK edges are allowed.
- HOLD: SCLK=0 for CS_HOLD cycles. On exit edge: CS_N<=1, DOUT<=RX register, DOUT_VLD<=1 for exactly one cycle, go GAP.
- GAP: CS_N=1 for CS_GAP cycles, then IDLE with DIN_RDY=1.
- Default timing from T0:
  - CS_N high at T0+520.
  - DIN_RDY high at T0+528.
  - Back-to-back frames every 529 cycles, including the accept cycle.
- DIN_VLD while DIN_RDY=0 is ignored. DIN may change freely after acceptance. A word held valid is taken on the first IDLE edge.
- The MISO bit sampled at the first rising edge becomes DOUT[WIDTH-1].
- DOUT holds its value until the next completed frame.
- Reset mid-frame:
  - The frame is abandoned: CS_N=1 and SCLK=0 immediately (asynchronous).
  - No DOUT_VLD is produced and DOUT returns to 0.
  - The slave sees a truncated frame. That is acceptable and is required to be discarded by spi_slave.
- MISO is not synchronised. The slave updates MISO on SCLK fall, so it is stable for ≥CLK_DIV cycles before sampling.

Test Plan:
1. Loopback (MISO=MOSI), defaults, DIN=64'h0100000000000022 pulsed at T0 -> exactly 64 SCLK rises. First rise at T0+8. CS_N low T0..T0+520. DOUT=64'h0100000000000022 with DOUT_VLD high one cycle at T0+520. DIN_RDY high at T0+528.
2. Bench MISO model returning 64'hA5A5_5A5A_0F0F_F0F0 (updated on SCLK fall) with DIN=64'hFFFF_FFFF_FFFF_FFFF -> DOUT=64'hA5A5_5A5A_0F0F_F0F0. MOSI is high during every SCLK high phase.
3. DIN_VLD held high with 64'h1 then 64'h8000_0000_0000_0000 -> two frames. Second CS_N fall exactly 529 cycles after the first. A change on DIN during the first frame does not affect the first frame's MOSI bits.
4. RST_N low for 3 cycles at T0+200 -> CS_N=1 and SCLK=0 within the same cycle. No DOUT_VLD, DOUT=0. A new frame completes normally afterwards.
5. CLK_DIV=2, WIDTH=8, DIN=8'hC3, loopback -> SCLK period 4 CLK cycles, 8 rises, DOUT=8'hC3.
6. DIN_VLD=0 for 1000 cycles after reset -> CS_N=1, SCLK=0, BUSY=0, no DOUT_VLD.
